// File: rtl/rtc_bus_reader_if.sv
`default_nettype none
// ============================================================================
// rtc_bus_reader_if : multiplexed address/data strobe bus to the external RTC
// Revision 1.0
// ============================================================================
interface rtc_bus_reader_if;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;

  modport master (
    input  ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );

  modport slave (
    output ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_reader.sv
`default_nettype none
// ============================================================================
// rtc_bus_reader : periodically reads nine BCD time registers from the RTC
// Revision 1.0
// ============================================================================
module rtc_bus_reader #(
  parameter int T_PHASE        = 10,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              read_now,
  rtc_bus_reader_if.master bus,
  output logic             busy,
  output logic             valid,
  output logic [7:0]       dia,
  output logic [7:0]       mes,
  output logic [7:0]       ano,
  output logic [7:0]       horar,
  output logic [7:0]       minr,
  output logic [7:0]       segr,
  output logic [7:0]       horat,
  output logic [7:0]       mint,
  output logic [7:0]       segt
);
  localparam int c_cnt_w  = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam int c_idle_w = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(T_PHASE - 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(REFRESH_CYCLES - 1);
  localparam logic [3:0]          c_last_idx  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_AGAP   = 3'd2,
    S_DATA   = 3'd3,
    S_DGAP   = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idle_w-1:0] r_idle;
  logic [3:0]          r_idx;
  logic                r_pwrup;
  logic [7:0]          r_shadow [0:8];
  logic [7:0]          w_addr;
  logic                w_phase_end;
  logic                w_start;

  assign w_phase_end = (r_cnt == c_cnt_last);
  // r_pwrup forces the first read straight after reset release
  assign w_start     = r_pwrup | read_now | (r_idle == c_idle_last);

  always_comb begin
    w_addr = 8'h00;
    case (r_idx)
      4'd0:    w_addr = 8'h21;
      4'd1:    w_addr = 8'h22;
      4'd2:    w_addr = 8'h23;
      4'd3:    w_addr = 8'h24;
      4'd4:    w_addr = 8'h25;
      4'd5:    w_addr = 8'h26;
      4'd6:    w_addr = 8'h41;
      4'd7:    w_addr = 8'h42;
      4'd8:    w_addr = 8'h43;
      default: w_addr = 8'h00;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    bus.cs_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.a_d    = 1'b1;
    bus.ad_oe  = 1'b0;
    bus.ad_out = 8'h00;
    busy       = 1'b1;
    valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = S_ADDR;
      end
      S_ADDR: begin
        bus.cs_n   = 1'b0;
        bus.a_d    = 1'b0;
        bus.wr_n   = 1'b0;
        bus.ad_oe  = 1'b1;
        bus.ad_out = w_addr;
        if (w_phase_end) w_next = S_AGAP;
      end
      S_AGAP: begin
        // keep driving the address after cs_n rises for RTC hold time
        bus.a_d    = 1'b0;
        bus.ad_oe  = 1'b1;
        bus.ad_out = w_addr;
        if (w_phase_end) w_next = S_DATA;
      end
      S_DATA: begin
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        if (w_phase_end) w_next = S_DGAP;
      end
      S_DGAP: begin
        if (w_phase_end) w_next = (r_idx == c_last_idx) ? S_COMMIT : S_ADDR;
      end
      S_COMMIT: begin
        valid  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_idx   <= 4'd0;
      r_pwrup <= 1'b1;
      for (int i = 0; i < 9; i++) r_shadow[i] <= 8'h00;
      dia   <= 8'h00;
      mes   <= 8'h00;
      ano   <= 8'h00;
      horar <= 8'h00;
      minr  <= 8'h00;
      segr  <= 8'h00;
      horat <= 8'h00;
      mint  <= 8'h00;
      segt  <= 8'h00;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE || r_state == S_COMMIT || w_phase_end) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE) begin
        r_idle <= w_start ? '0 : r_idle + 1'b1;
        if (w_start) r_pwrup <= 1'b0;
      end

      if (r_state == S_DATA && w_phase_end) r_shadow[r_idx] <= bus.ad_in;

      if (r_state == S_DGAP && w_phase_end && r_idx != c_last_idx) r_idx <= r_idx + 4'd1;
      else if (r_state == S_COMMIT) r_idx <= 4'd0;

      // load on the edge into COMMIT so new data is visible alongside valid
      if (r_state == S_DGAP && w_next == S_COMMIT) begin
        segr  <= r_shadow[0];
        minr  <= r_shadow[1];
        horar <= r_shadow[2];
        dia   <= r_shadow[3];
        mes   <= r_shadow[4];
        ano   <= r_shadow[5];
        segt  <= r_shadow[6];
        mint  <= r_shadow[7];
        horat <= r_shadow[8];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_reader.sv
`default_nettype none
// ============================================================================
// tb_rtc_bus_reader : randomized bench with a behavioural RTC and timing model
// Revision 1.0
// ============================================================================
module tb_rtc_bus_reader;
  localparam logic [7:0] REG_ADDR [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                         8'h26, 8'h41, 8'h42, 8'h43};
  localparam int PH      = 10;
  localparam int SEQ_LEN = 36 * PH + 1;
  localparam int GAP     = 50;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       read_now = 1'b0;
  logic       busy;
  logic       valid;
  logic [7:0] dia, mes, ano, horar, minr, segr, horat, mint, segt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rtc_addr = 8'h00;
  logic [7:0] noise    = 8'h00;

  rtc_bus_reader_if bus ();

  rtc_bus_reader #(.T_PHASE(PH), .REFRESH_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read_now (read_now),
    .bus      (bus),
    .busy     (busy),
    .valid    (valid),
    .dia      (dia),
    .mes      (mes),
    .ano      (ano),
    .horar    (horar),
    .minr     (minr),
    .segr     (segr),
    .horat    (horat),
    .mint     (mint),
    .segt     (segt)
  );

  always #5 clk = ~clk;

  // RTC: latch address during write strobe, return register during read strobe
  always @(posedge clk) if (!bus.cs_n && !bus.wr_n && !bus.a_d) rtc_addr <= bus.ad_out;
  always @(negedge clk) noise <= 8'($urandom);
  assign bus.ad_in = (!bus.cs_n && !bus.rd_n && bus.a_d) ? mem[rtc_addr] : noise;

  function automatic logic [71:0] outs();
    return {segr, minr, horar, dia, mes, ano, segt, mint, horat};
  endfunction

  function automatic logic [71:0] rand72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic load_rtc(input logic [71:0] v);
    for (int k = 0; k < 9; k++) mem[REG_ADDR[k]] = v[71-8*k -: 8];
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, busy, valid, bus.ad_out} !==
        {4'b1111, 3'b000, 8'h00}) begin
      failures++;
      $display("FAIL reset_bus got=%b exp=%b",
               {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, busy, valid, bus.ad_out},
               {4'b1111, 3'b000, 8'h00});
    end
    checks++;
    if (outs() !== 72'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", outs());
    end
  endtask

  task automatic test_powerup();
    logic [71:0] exp_v = 72'h45_30_17_02_04_17_20_05_01;
    logic [71:0] got   = 72'h0;
    logic        b1    = 1'b0;
    int          first = 0;
    load_rtc(exp_v);
    rst_n = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) b1 = busy;
      if (valid) begin
        first = n;
        got   = outs();
        break;
      end
    end
    checks++;
    if (b1 !== 1'b1) begin failures++; $display("FAIL powerup_busy got=%b exp=1", b1); end
    checks++;
    if (first != SEQ_LEN) begin failures++; $display("FAIL powerup_latency got=%0d exp=%0d", first, SEQ_LEN); end
    checks++;
    if (got !== exp_v) begin failures++; $display("FAIL powerup_data got=%h exp=%h", got, exp_v); end
    @(negedge clk);
    checks++;
    if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL powerup_after got=%b exp=00", {valid, busy}); end
  endtask

  task automatic test_protocol();
    logic [71:0] exp_v = rand72();
    logic [7:0]  addrs [$];
    int n = 0, wr_run = 0, rd_run = 0, nwr = 0, nrd = 0;
    int bad_len = 0, overlap = 0, drive_rd = 0, bad_ctl = 0, bad_addr = 0;
    load_rtc(exp_v);
    read_now = 1'b1;
    do begin
      @(negedge clk);
      n++;
      read_now = 1'b0;
      if (!bus.rd_n && !bus.wr_n) overlap++;
      if (bus.ad_oe && !bus.rd_n) drive_rd++;
      if (!bus.wr_n) begin
        if (bus.cs_n || bus.a_d || !bus.ad_oe) bad_ctl++;
        if (wr_run == 0) addrs.push_back(bus.ad_out);
        wr_run++;
      end else if (wr_run != 0) begin
        nwr++;
        if (wr_run != PH) bad_len++;
        wr_run = 0;
      end
      if (!bus.rd_n) begin
        if (bus.cs_n || !bus.a_d) bad_ctl++;
        rd_run++;
      end else if (rd_run != 0) begin
        nrd++;
        if (rd_run != PH) bad_len++;
        rd_run = 0;
      end
    end while (!valid && n < 500);
    checks++;
    if (n != SEQ_LEN) begin failures++; $display("FAIL proto_length got=%0d exp=%0d", n, SEQ_LEN); end
    checks++;
    if (nwr != 9 || nrd != 9) begin failures++; $display("FAIL proto_strobe_count got=%0d/%0d exp=9/9", nwr, nrd); end
    checks++;
    if (bad_len != 0) begin failures++; $display("FAIL proto_strobe_len got=%0d bad exp=0", bad_len); end
    checks++;
    if (overlap != 0 || drive_rd != 0) begin
      failures++; $display("FAIL proto_overlap got=%0d/%0d exp=0/0", overlap, drive_rd);
    end
    checks++;
    if (bad_ctl != 0) begin failures++; $display("FAIL proto_ctl got=%0d bad exp=0", bad_ctl); end
    for (int k = 0; k < 9; k++)
      if (k >= addrs.size() || addrs[k] !== REG_ADDR[k]) bad_addr++;
    checks++;
    if (bad_addr != 0 || addrs.size() != 9) begin
      failures++; $display("FAIL proto_addr_order got=%0d wrong of %0d exp=0 of 9", bad_addr, addrs.size());
    end
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL proto_data got=%h exp=%h", outs(), exp_v); end
  endtask

  task automatic test_atomicity();
    logic [71:0] prev, oldv, newv, got, exp_v;
    int n = 0, changes = 0, unstable = 0;
    @(negedge clk);
    prev = outs();
    oldv = rand72();
    newv = rand72();
    // registers 0..3 are read before the switch point, 4..8 after it
    exp_v = {oldv[71:40], newv[39:0]};
    load_rtc(oldv);
    read_now = 1'b1;
    do begin
      @(negedge clk);
      n++;
      read_now = 1'b0;
      if (n == 4 * 4 * PH + 5) load_rtc(newv);
      if (!valid && outs() !== prev) changes++;
    end while (!valid && n < 500);
    got = outs();
    checks++;
    if (n != SEQ_LEN) begin failures++; $display("FAIL atomic_length got=%0d exp=%0d", n, SEQ_LEN); end
    checks++;
    if (changes != 0) begin failures++; $display("FAIL atomic_early_change got=%0d exp=0", changes); end
    checks++;
    if (got !== exp_v) begin failures++; $display("FAIL atomic_data got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (outs() !== got) unstable++;
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL atomic_hold got=%0d exp=0", unstable); end
  endtask

  task automatic test_read_now();
    int n = 0, g = 0;
    logic [71:0] exp_v = rand72();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL rn_wait_valid got=%b exp=1", valid); end
    read_now = 1'b1;
    @(negedge clk);
    read_now = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rn_commit_ignored got=%b exp=0", busy); end
    load_rtc(exp_v);
    read_now = 1'b1;
    @(negedge clk);
    read_now = 1'b0;
    n = 1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rn_start got=%b exp=1", busy); end
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (valid) break;
      read_now = ($urandom_range(0, 3) == 0);
    end
    read_now = 1'b0;
    checks++;
    if (n != SEQ_LEN) begin failures++; $display("FAIL rn_length got=%0d exp=%0d", n, SEQ_LEN); end
    checks++;
    if (outs() !== exp_v) begin failures++; $display("FAIL rn_data got=%h exp=%h", outs(), exp_v); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) break;
      g++;
    end
    checks++;
    if (g != GAP) begin failures++; $display("FAIL rn_not_queued gap got=%0d exp=%0d", g, GAP); end
  endtask

  task automatic test_refresh();
    for (int rep = 0; rep < 4; rep++) begin
      logic [71:0] v   = (rep == 1) ? {9{8'hFF}} : rand72();
      logic [71:0] got = 72'h0;
      int len = 1, vcnt = 0, gap = 1;
      load_rtc(v);
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (!busy) break;
        len++;
        if (valid) begin vcnt++; got = outs(); end
      end
      checks++;
      if (len != SEQ_LEN || vcnt != 1) begin
        failures++; $display("FAIL refresh_seq rep=%0d got=%0d/%0d exp=%0d/1", rep, len, vcnt, SEQ_LEN);
      end
      checks++;
      if (got !== v) begin failures++; $display("FAIL refresh_data rep=%0d got=%h exp=%h", rep, got, v); end
      for (int i = 0; i < 200; i++) begin
        // rep 2 lands read_now exactly on the refresh terminal count
        if (rep == 2 && gap == GAP) read_now = 1'b1;
        @(negedge clk);
        read_now = 1'b0;
        if (busy) break;
        gap++;
      end
      checks++;
      if (gap != GAP) begin failures++; $display("FAIL refresh_gap rep=%0d got=%0d exp=%0d", rep, gap, GAP); end
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] v = rand72();
    logic        b1;
    int          n = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, busy, valid, bus.ad_out} !==
        {4'b1111, 3'b000, 8'h00}) begin
      failures++;
      $display("FAIL midreset_bus got=%b exp=%b",
               {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, busy, valid, bus.ad_out},
               {4'b1111, 3'b000, 8'h00});
    end
    checks++;
    if (outs() !== 72'h0) begin failures++; $display("FAIL midreset_outs got=%h exp=0", outs()); end
    @(negedge clk);
    load_rtc(v);
    rst_n = 1'b1;
    @(negedge clk);
    n  = 1;
    b1 = busy;
    checks++;
    if (b1 !== 1'b1) begin failures++; $display("FAIL midreset_restart got=%b exp=1", b1); end
    while (!valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != SEQ_LEN) begin failures++; $display("FAIL midreset_length got=%0d exp=%0d", n, SEQ_LEN); end
    checks++;
    if (outs() !== v) begin failures++; $display("FAIL midreset_data got=%h exp=%h", outs(), v); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_powerup();
    test_protocol();
    test_atomicity();
    test_read_now();
    test_refresh();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
